ncpu64k_sram_wbuf: RTL and testbench

- Write buffer directly upstream of the single-port byte-enable SRAM macro wrapper (one address, RE, byte WE, 1-cycle read latency).
- Queues byte-masked writes and drains them into the SRAM only in cycles with no read, so reads are never stalled.
- Read data returned to the requester is forwarded (byte-merged) from pending entries, giving read-after-write coherency.
- Used in front of cache data/tag arrays.

---
 rtl/ncpu64k_sram_wbuf_pkg.sv | 13 +
 rtl/ncpu64k_wbuf_fwd.sv | 62 ++++++
 rtl/ncpu64k_sram_wbuf.sv | 190 +++++++++++++++++++
 tb/tb_ncpu64k_sram_wbuf.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ncpu64k_sram_wbuf_pkg.sv
// ncpu64k_sram_wbuf_pkg
//   Shared defaults for the SRAM write buffer and its forwarding network.
//   WBUF_P_DW    : log2 of the data width in bits (6 -> 64-bit words)
//   WBUF_AW      : SRAM word address width
//   WBUF_DEPTH_P : log2 of the number of buffer entries
//   Optional feature macro (consumed by the top): NCPU_WBUF_COALESCE_EN
package ncpu64k_sram_wbuf_pkg;

    localparam int WBUF_P_DW    = 6;
    localparam int WBUF_AW      = 6;
    localparam int WBUF_DEPTH_P = 2;

endpackage

// File: rtl/ncpu64k_wbuf_fwd.sv
// ncpu64k_wbuf_fwd
//   Combinational read-forwarding network. Walks the valid buffer entries
//   from oldest to newest and then the write accepted in the same cycle,
//   so later writes override earlier ones byte by byte.
// Ports:
//   ent_addr/ent_be/ent_dat : entry array (indexed by physical slot)
//   head, count             : oldest slot and number of valid entries
//   wr_en/waddr/wbe/wdat    : write accepted this cycle (counts as newest)
//   raddr                   : read address being issued
//   fwd_mask/fwd_dat        : bytes to take from the buffer instead of SRAM
module ncpu64k_wbuf_fwd
    import ncpu64k_sram_wbuf_pkg::*;
#(
    parameter int P_DW    = WBUF_P_DW,
    parameter int AW      = WBUF_AW,
    parameter int DEPTH_P = WBUF_DEPTH_P
) (
    input  logic [AW-1:0]         ent_addr [1<<DEPTH_P],
    input  logic [(1<<P_DW)/8-1:0] ent_be  [1<<DEPTH_P],
    input  logic [(1<<P_DW)-1:0]  ent_dat  [1<<DEPTH_P],
    input  logic [DEPTH_P-1:0]    head,
    input  logic [DEPTH_P:0]      count,
    input  logic                  wr_en,
    input  logic [AW-1:0]         waddr,
    input  logic [(1<<P_DW)/8-1:0] wbe,
    input  logic [(1<<P_DW)-1:0]  wdat,
    input  logic [AW-1:0]         raddr,
    output logic [(1<<P_DW)/8-1:0] fwd_mask,
    output logic [(1<<P_DW)-1:0]  fwd_dat
);

    localparam int BW   = (1 << P_DW) / 8;
    localparam int NENT = 1 << DEPTH_P;

    logic [DEPTH_P-1:0] idx;

    always_comb begin
        fwd_mask = '0;
        fwd_dat  = '0;
        idx      = '0;
        for (int k = 0; k < NENT; k++) begin
            idx = head + DEPTH_P'(k);
            if (count > (DEPTH_P+1)'(k) && ent_addr[idx] == raddr) begin
                for (int b = 0; b < BW; b++) begin
                    if (ent_be[idx][b]) begin
                        fwd_mask[b]       = 1'b1;
                        fwd_dat[b*8 +: 8] = ent_dat[idx][b*8 +: 8];
                    end
                end
            end
        end
        if (wr_en && waddr == raddr) begin
            for (int b = 0; b < BW; b++) begin
                if (wbe[b]) begin
                    fwd_mask[b]       = 1'b1;
                    fwd_dat[b*8 +: 8] = wdat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ncpu64k_sram_wbuf.sv
// ncpu64k_sram_wbuf
//   Write buffer in front of a single-port byte-enable SRAM (1-cycle read).
//   Writes are queued and drained only in cycles without a read, so reads
//   are never stalled; read data is byte-merged with pending writes.
// Ports:
//   CLK, RST (async, active-high)
//   i_re/i_raddr -> o_rvalid/o_rdat (one cycle later)
//   i_we/i_waddr/i_wdat, o_wready : byte-masked write request / accept
//   o_empty                       : no pending entries
//   o_ram_addr/o_ram_re/o_ram_we/o_ram_din, i_ram_dout : SRAM interface
// Optional feature: define NCPU_WBUF_COALESCE_EN to merge a write into the
//   newest entry when the address matches.
module ncpu64k_sram_wbuf
    import ncpu64k_sram_wbuf_pkg::*;
#(
    parameter int P_DW    = WBUF_P_DW,
    parameter int AW      = WBUF_AW,
    parameter int DEPTH_P = WBUF_DEPTH_P
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_re,
    input  logic [AW-1:0]          i_raddr,
    output logic                   o_rvalid,
    output logic [(1<<P_DW)-1:0]   o_rdat,
    input  logic [(1<<P_DW)/8-1:0] i_we,
    input  logic [AW-1:0]          i_waddr,
    input  logic [(1<<P_DW)-1:0]   i_wdat,
    output logic                   o_wready,
    output logic                   o_empty,
    output logic [AW-1:0]          o_ram_addr,
    output logic                   o_ram_re,
    output logic [(1<<P_DW)/8-1:0] o_ram_we,
    output logic [(1<<P_DW)-1:0]   o_ram_din,
    input  logic [(1<<P_DW)-1:0]   i_ram_dout
);

    localparam int DW   = 1 << P_DW;
    localparam int BW   = DW / 8;
    localparam int NENT = 1 << DEPTH_P;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_d,
                                                 input logic [DW-1:0] new_d,
                                                 input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    logic [DEPTH_P:0]   head_q, head_d, tail_q, tail_d, count;
    logic [DEPTH_P-1:0] head_idx, tail_idx;
    logic [AW-1:0]      ent_addr_q [NENT];
    logic [AW-1:0]      ent_addr_d [NENT];
    logic [BW-1:0]      ent_be_q   [NENT];
    logic [BW-1:0]      ent_be_d   [NENT];
    logic [DW-1:0]      ent_dat_q  [NENT];
    logic [DW-1:0]      ent_dat_d  [NENT];
    logic               full, empty, wr_req, drain, merge, push, accept;
    logic               rvalid_q, rvalid_d;
    logic [BW-1:0]      fwd_mask, fwd_mask_q, fwd_mask_d;
    logic [DW-1:0]      fwd_dat, fwd_dat_q, fwd_dat_d;

    assign head_idx = head_q[DEPTH_P-1:0];
    assign tail_idx = tail_q[DEPTH_P-1:0];
    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[DEPTH_P] != tail_q[DEPTH_P]) &&
                      (head_q[DEPTH_P-1:0] == tail_q[DEPTH_P-1:0]);
    assign wr_req   = |i_we;
    // Reads own the SRAM port; draining only happens in read-free cycles.
    assign drain    = !i_re && !empty;

`ifdef NCPU_WBUF_COALESCE_EN
    logic [DEPTH_P-1:0] newest_idx;
    assign newest_idx = tail_idx - 1'b1;
    // The newest entry cannot absorb a write while it is leaving the buffer.
    assign merge = wr_req && !empty && (ent_addr_q[newest_idx] == i_waddr) &&
                   !(drain && count == (DEPTH_P+1)'(1));
`else
    assign merge = 1'b0;
`endif

    assign o_wready = !full || merge;
    assign accept   = wr_req && o_wready;
    assign push     = accept && !merge;
    assign o_empty  = empty;

    always_comb begin
        head_d = head_q + (DEPTH_P+1)'(drain);
        tail_d = tail_q + (DEPTH_P+1)'(push);
    end

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_be_d   = ent_be_q;
        ent_dat_d  = ent_dat_q;
        if (push) begin
            ent_addr_d[tail_idx] = i_waddr;
            ent_be_d[tail_idx]   = i_we;
            ent_dat_d[tail_idx]  = i_wdat;
        end
`ifdef NCPU_WBUF_COALESCE_EN
        if (merge) begin
            ent_be_d[newest_idx]  = ent_be_q[newest_idx] | i_we;
            ent_dat_d[newest_idx] = byte_merge(ent_dat_q[newest_idx], i_wdat, i_we);
        end
`endif
    end

    always_comb begin
        o_ram_re   = i_re;
        o_ram_addr = '0;
        o_ram_we   = '0;
        o_ram_din  = '0;
        if (i_re) begin
            o_ram_addr = i_raddr;
        end else if (drain) begin
            o_ram_addr = ent_addr_q[head_idx];
            o_ram_we   = ent_be_q[head_idx];
            o_ram_din  = ent_dat_q[head_idx];
        end
    end

    ncpu64k_wbuf_fwd #(
        .P_DW    (P_DW),
        .AW      (AW),
        .DEPTH_P (DEPTH_P)
    ) u_fwd (
        .ent_addr (ent_addr_q),
        .ent_be   (ent_be_q),
        .ent_dat  (ent_dat_q),
        .head     (head_idx),
        .count    (count),
        .wr_en    (accept),
        .waddr    (i_waddr),
        .wbe      (i_we),
        .wdat     (i_wdat),
        .raddr    (i_raddr),
        .fwd_mask (fwd_mask),
        .fwd_dat  (fwd_dat)
    );

    // Forward snapshot taken at read issue; SRAM supplies the rest next cycle.
    always_comb begin
        rvalid_d   = i_re;
        fwd_mask_d = i_re ? fwd_mask : fwd_mask_q;
        fwd_dat_d  = i_re ? fwd_dat  : fwd_dat_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q   <= '0;
            tail_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge CLK) begin
        ent_addr_q <= ent_addr_d;
        ent_be_q   <= ent_be_d;
        ent_dat_q  <= ent_dat_d;
        fwd_mask_q <= fwd_mask_d;
        fwd_dat_q  <= fwd_dat_d;
    end

    assign o_rvalid = rvalid_q;
    assign o_rdat   = byte_merge(i_ram_dout, fwd_dat_q, fwd_mask_q);

`ifndef SYNTHESIS
    // SRAM output is undefined in the cycle after a write; read priority
    // must keep a read from completing then.
    logic drained_q, drained_d;
    assign drained_d = drain;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) drained_q <= 1'b0;
        else     drained_q <= drained_d;
    end
    always_ff @(posedge CLK) begin
        if (!RST && rvalid_q)
            assert (!drained_q) else $error("read completed in cycle after drain");
    end
`endif

endmodule

// File: tb/tb_ncpu64k_sram_wbuf.sv
module tb_ncpu64k_sram_wbuf;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int N  = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          i_re;
    logic [AW-1:0] i_raddr;
    logic          o_rvalid;
    logic [DW-1:0] o_rdat;
    logic [BW-1:0] i_we;
    logic [AW-1:0] i_waddr;
    logic [DW-1:0] i_wdat;
    logic          o_wready;
    logic          o_empty;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_re;
    logic [BW-1:0] o_ram_we;
    logic [DW-1:0] o_ram_din;
    logic [DW-1:0] ram_dout;

    always #5 CLK = ~CLK;

    ncpu64k_sram_wbuf dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_re       (i_re),
        .i_raddr    (i_raddr),
        .o_rvalid   (o_rvalid),
        .o_rdat     (o_rdat),
        .i_we       (i_we),
        .i_waddr    (i_waddr),
        .i_wdat     (i_wdat),
        .o_wready   (o_wready),
        .o_empty    (o_empty),
        .o_ram_addr (o_ram_addr),
        .o_ram_re   (o_ram_re),
        .o_ram_we   (o_ram_we),
        .o_ram_din  (o_ram_din),
        .i_ram_dout (ram_dout)
    );

    // SRAM behavioural model: 1-cycle read, garbage output after a write.
    logic [DW-1:0] sram [1<<AW];
    logic          sram_clr;
    always @(posedge CLK) begin
        if (sram_clr) begin
            for (int i = 0; i < (1<<AW); i++) sram[i] <= '0;
            ram_dout <= '0;
        end else if (o_ram_re) begin
            ram_dout <= sram[o_ram_addr];
        end else if (|o_ram_we) begin
            for (int b = 0; b < BW; b++)
                if (o_ram_we[b]) sram[o_ram_addr][b*8 +: 8] <= o_ram_din[b*8 +: 8];
            ram_dout <= {$urandom, $urandom};
        end
    end

    // Reference: logical memory image plus FIFO of pending writes.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    logic [DW-1:0] ref_mem [1<<AW];
    bit            pend_rd;
    logic [DW-1:0] pend_dat;
    int            checks;
    int            fails;

    function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit re, input logic [AW-1:0] ra, input logic [BW-1:0] we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        i_re = re; i_raddr = ra; i_we = we; i_waddr = wa; i_wdat = wd;
    endtask

    // One clock cycle: drive, check combinational and registered outputs
    // against the model, advance the model, then step past the edge.
    task automatic cycle(input bit re, input logic [AW-1:0] ra, input logic [BW-1:0] we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit exp_wready, acc, pop, mrg;
        wr_t e;
        drive(re, ra, we, wa, wd);
        #1;
        pop = !re && q.size() != 0;
        mrg = 1'b0;
`ifdef NCPU_WBUF_COALESCE_EN
        if (we != 0 && q.size() != 0 && q[q.size()-1].a == wa && !(pop && q.size() == 1))
            mrg = 1'b1;
`endif
        exp_wready = (q.size() < N) || mrg;
        acc        = (we != 0) && exp_wready;
        chk("wready", o_wready, exp_wready);
        chk("empty", o_empty, q.size() == 0);
        chk("ram_re", o_ram_re, re);
        if (re) begin
            chk("ram_addr_rd", o_ram_addr, ra);
            chk("ram_we_rd", o_ram_we, 0);
        end else if (pop) begin
            chk("drain_addr", o_ram_addr, q[0].a);
            chk("drain_be", o_ram_we, q[0].be);
            chk("drain_din", o_ram_din, q[0].d);
        end else begin
            chk("ram_we_idle", o_ram_we, 0);
        end
        chk("rvalid", o_rvalid, pend_rd);
        if (pend_rd) chk("rdat", o_rdat, pend_dat);
        if (pop) void'(q.pop_front());
        if (acc) begin
            ref_mem[wa] = bmerge(ref_mem[wa], wd, we);
            if (mrg) begin
                q[q.size()-1].be = q[q.size()-1].be | we;
                q[q.size()-1].d  = bmerge(q[q.size()-1].d, wd, we);
            end else begin
                e.a = wa; e.be = we; e.d = wd;
                q.push_back(e);
            end
        end
        pend_rd = re;
        if (re) pend_dat = ref_mem[ra];
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        pend_rd = 1'b0;
        pend_dat = '0;
        RST = 1'b1;
        sram_clr = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        @(posedge CLK);
        @(posedge CLK);
        sram_clr = 1'b0;
        #1;
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_wready", o_wready, 1);
        chk("rst_ram_re", o_ram_re, 0);
        chk("rst_ram_we", o_ram_we, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Single write drains one cycle after acceptance.
        cycle(1'b0, '0, 8'hFF, 6'd5, 64'h1122334455667788);
        drive(1'b0, '0, '0, '0, '0);
        #1;
        chk("t1_ram_we", o_ram_we, 8'hFF);
        chk("t1_ram_addr", o_ram_addr, 6'd5);
        chk("t1_ram_din", o_ram_din, 64'h1122334455667788);
        idle(1);
        chk("t1_empty_after", o_empty, 1);

        // Same-cycle write forwarding merged with SRAM data.
        cycle(1'b0, '0, 8'hFF, 6'd3, 64'h1111111122222222);
        idle(1);
        cycle(1'b1, 6'd3, 8'h0F, 6'd3, 64'hAAAAAAAABBBBBBBB);
        chk("t2_rvalid", o_rvalid, 1);
        chk("t2_rdat", o_rdat, 64'h11111111BBBBBBBB);
        idle(1);

        // Reads held continuously: buffer fills, no drain, then drains in order.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 6'd10, 8'hFF, 6'(10 + i), {32'hC0DE0000 + 32'(i), 32'h12345678});
        drive(1'b1, 6'd11, 8'hFF, 6'd14, 64'hDEADBEEFDEADBEEF);
        #1;
        chk("t3_wready_full", o_wready, 0);
        chk("t3_no_drain", o_ram_we, 0);
        cycle(1'b1, 6'd11, 8'hFF, 6'd14, 64'hDEADBEEFDEADBEEF);
        idle(4);
        chk("t3_empty_after", o_empty, 1);

        // Two writes to one address: newest byte wins.
        cycle(1'b1, 6'd0, 8'h01, 6'd7, 64'h00000000000000AA);
        cycle(1'b1, 6'd0, 8'h01, 6'd7, 64'h00000000000000CC);
        cycle(1'b1, 6'd7, 8'h00, 6'd0, 64'h0);
        chk("t4_byte0", o_rdat[7:0], 8'hCC);
        idle(3);

        // Reset with three pending entries and a read in flight.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 6'd1, 8'hFF, 6'(20 + i), {$urandom, $urandom});
        drive(1'b0, '0, '0, '0, '0);
        RST = 1'b1;
        #1;
        chk("t5_rvalid", o_rvalid, 0);
        chk("t5_empty", o_empty, 1);
        chk("t5_ram_we", o_ram_we, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        q.delete();
        pend_rd = 1'b0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = sram[i];
        @(posedge CLK);
        #1;
        idle(3);
        chk("t5_discarded", sram[20], ref_mem[20]);

        // Randomized mixed traffic over a small address window.
        for (int i = 0; i < 1500; i++) begin
            bit            re;
            logic [BW-1:0] we;
            re = ($urandom_range(0, 9) < 4);
            we = ($urandom_range(0, 1) == 1) ? BW'($urandom) : '0;
            cycle(re, 6'($urandom_range(0, 7)), we, 6'($urandom_range(0, 7)),
                  {$urandom, $urandom});
        end
        idle(6);
        for (int a = 0; a < 8; a++) chk("final_mem", sram[a], ref_mem[a]);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
